// File: rtl/inst_trace_buf_if.sv
// Retire-trace bus: retire lanes in, drained FWFT entries out, status.
// Ports: in_valid/in_pc/in_inst/in_ready, out_*, count, dropped, overflow.
interface inst_trace_buf_if #(
    parameter int NLANES = 2,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 32,
    parameter int DROP_W = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NLANES-1:0]    in_valid;
    logic [NLANES*32-1:0] in_pc;
    logic [NLANES*32-1:0] in_inst;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_pc;
    logic [31:0]          out_inst;
    logic [SEQ_W-1:0]     out_seq;
    string                out_str;
    logic [CW-1:0]        count;
    logic [DROP_W-1:0]    dropped;
    logic                 overflow;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_seq,
        input  out_str, count, dropped, overflow
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_seq,
        output out_str, count, dropped, overflow
    );
endinterface

// File: rtl/inst_trace_buf.sv
// Simulation-only retire trace buffer with MIPS disassembly of the head entry.
// Ports: clock, reset (sync, active-high), bus (inst_trace_buf_if.slave).
// Optional: define TRACE_PRINT_EN to print every pop and every drop cycle.
module text_idec (
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output string       o_str
);
    function automatic string disasm(input logic [31:0] ins,
                                     input logic [31:0] pc);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [31:0] simm;
        logic [31:0] npc;
        string       s;
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        simm = {{16{ins[15]}}, ins[15:0]};
        npc  = pc + 32'd4;
        s    = $sformatf(".word 0x%08x", ins);
        case (op)
            6'h00: begin
                case (fn)
                    6'h00: s = (ins == 32'd0) ? "nop" :
                        $sformatf("sll $%0d, $%0d, %0d", rd, rt, sh);
                    6'h08: s = $sformatf("jr $%0d", rs);
                    6'h21: s = $sformatf("addu $%0d, $%0d, $%0d", rd, rs, rt);
                    6'h23: s = $sformatf("subu $%0d, $%0d, $%0d", rd, rs, rt);
                    6'h24: s = $sformatf("and $%0d, $%0d, $%0d", rd, rs, rt);
                    6'h25: s = $sformatf("or $%0d, $%0d, $%0d", rd, rs, rt);
                    6'h2a: s = $sformatf("slt $%0d, $%0d, $%0d", rd, rs, rt);
                    default: ;
                endcase
            end
            // jump targets keep the upper nibble of the delay-slot pc
            6'h02: s = $sformatf("j 0x%08x", {npc[31:28], ins[25:0], 2'b00});
            6'h03: s = $sformatf("jal 0x%08x", {npc[31:28], ins[25:0], 2'b00});
            6'h04: s = $sformatf("beq $%0d, $%0d, 0x%08x", rs, rt,
                                 npc + (simm << 2));
            6'h05: s = $sformatf("bne $%0d, $%0d, 0x%08x", rs, rt,
                                 npc + (simm << 2));
            6'h09: s = $sformatf("addiu $%0d, $%0d, %0d", rt, rs,
                                 $signed(simm));
            6'h0c: s = $sformatf("andi $%0d, $%0d, 0x%0h", rt, rs, ins[15:0]);
            6'h0d: s = $sformatf("ori $%0d, $%0d, 0x%0h", rt, rs, ins[15:0]);
            6'h0f: s = $sformatf("lui $%0d, 0x%0h", rt, ins[15:0]);
            6'h23: s = $sformatf("lw $%0d, %0d($%0d)", rt, $signed(simm), rs);
            6'h2b: s = $sformatf("sw $%0d, %0d($%0d)", rt, $signed(simm), rs);
            default: ;
        endcase
        return s;
    endfunction

    always_comb o_str = disasm(i_inst, i_pc);
endmodule

module inst_trace_buf #(
    parameter int NLANES = 2,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic           clock,
    input  logic           reset,
    inst_trace_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (NLANES < 1 || NLANES > 4 || DEPTH < 2 * NLANES ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("inst_trace_buf: illegal NLANES/DEPTH");
    end

    logic [31:0]       r_pc   [DEPTH];
    logic [31:0]       r_inst [DEPTH];
    logic [SEQ_W-1:0]  r_seq  [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic [SEQ_W-1:0]  r_next_seq;
    logic [DROP_W-1:0] r_dropped;
    logic              r_overflow;

    logic [2:0]        w_rank [NLANES];
    logic [2:0]        w_n;
    logic              w_ready;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DROP_W:0]   w_dsum;
    string             w_str;

    // Rank of each lane among the valid ones compresses mask gaps.
    always_comb begin
        logic [2:0] acc;
        acc = '0;
        for (int i = 0; i < NLANES; i++) begin
            w_rank[i] = acc;
            acc = acc + {2'b00, bus.in_valid[i]};
        end
        w_n = acc;
    end

    // Ready looks only at registered occupancy, never at a same-cycle pop.
    assign w_ready   = (CW'(DEPTH) - r_count) >= CW'(NLANES);
    assign w_push    = (w_n != 3'd0) && w_ready;
    assign w_drop    = (w_n != 3'd0) && !w_ready;
    assign w_pop     = (r_count != '0) && bus.out_ready;
    assign w_cnt_nxt = r_count + (w_push ? CW'(w_n) : '0)
                     - (w_pop ? CW'(1) : '0);
    assign w_dsum    = {1'b0, r_dropped} + (DROP_W + 1)'(w_n);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_next_seq <= '0;
            r_dropped  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(w_n);
            if (w_pop) r_head <= r_head + AW'(1);
            r_count <= w_cnt_nxt;
            // Sequence advances even on a drop so lost entries leave a gap.
            if (w_n != 3'd0) r_next_seq <= r_next_seq + SEQ_W'(w_n);
            if (w_drop) begin
                r_dropped  <= w_dsum[DROP_W] ? '1 : w_dsum[DROP_W-1:0];
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NLANES; i++) begin
            if (w_push && bus.in_valid[i]) begin
                r_pc[r_tail + AW'(w_rank[i])]   <= bus.in_pc[32*i +: 32];
                r_inst[r_tail + AW'(w_rank[i])] <= bus.in_inst[32*i +: 32];
                r_seq[r_tail + AW'(w_rank[i])]  <=
                    r_next_seq + SEQ_W'(w_rank[i]);
            end
        end
    end

    text_idec u_idec (
        .i_inst (r_inst[r_head]),
        .i_pc   (r_pc[r_head]),
        .o_str  (w_str)
    );

    // Head fields are masked while empty so unwritten storage never leaks.
    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_pc    = bus.out_valid ? r_pc[r_head] : '0;
    assign bus.out_inst  = bus.out_valid ? r_inst[r_head] : '0;
    assign bus.out_seq   = bus.out_valid ? r_seq[r_head] : '0;
    assign bus.count     = r_count;
    assign bus.dropped   = r_dropped;
    assign bus.overflow  = r_overflow;

    always_comb bus.out_str = (r_count != '0) ? w_str : "";

`ifdef TRACE_PRINT_EN
    always_ff @(posedge clock) begin
        if (!reset && w_pop)
            $display("[%0d] 0x%08x: %08x  %s", bus.out_seq, bus.out_pc,
                     bus.out_inst, bus.out_str);
        if (!reset && w_drop)
            $display("TRACE DROP n=%0d seq=%0d", w_n, r_next_seq);
    end
`endif
endmodule

// File: tb/tb_inst_trace_buf.sv
// Scoreboard bench for inst_trace_buf (NLANES=2, DEPTH=16).
// Ports: drives the bus interface, clock and reset.
module tb_inst_trace_buf;
    localparam int NL = 2;
    localparam int DP = 16;
    localparam int SW = 32;
    localparam int DW = 16;

    logic clock;
    logic reset;

    inst_trace_buf_if #(.NLANES(NL), .DEPTH(DP), .SEQ_W(SW), .DROP_W(DW)) bus ();

    inst_trace_buf #(.NLANES(NL), .DEPTH(DP), .SEQ_W(SW), .DROP_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int n_pass;
    int n_tot;

    int          m_cnt;
    logic [31:0] m_seq;
    int          m_drop;
    bit          m_ovf;

    logic [31:0] q_pc   [$];
    logic [31:0] q_inst [$];
    logic [31:0] q_seq  [$];
    string       q_str  [$];

    function automatic string h(input logic [63:0] v);
        return $sformatf("%0h", v);
    endfunction

    task automatic check(input string tag, input string got, input string exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got '%s' exp '%s'", tag, got, exp);
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_seq = '0;
        m_drop = 0;
        m_ovf = 1'b0;
        q_pc.delete();
        q_inst.delete();
        q_seq.delete();
        q_str.delete();
    endtask

    task automatic sb_push(input logic [31:0] p, input logic [31:0] i,
                           input logic [31:0] s, input string t);
        q_pc.push_back(p);
        q_inst.push_back(i);
        q_seq.push_back(s);
        q_str.push_back(t);
    endtask

    // One clock: check registered state, drive inputs, score any pop.
    task automatic tick(input logic [1:0] mask,
                        input logic [31:0] p0, input logic [31:0] i0,
                        input logic [31:0] p1, input logic [31:0] i1,
                        input bit rdy, input string s0, input string s1);
        bit    pop;
        bit    rd;
        int    n;
        string es;
        check("count", h(bus.count), h(m_cnt));
        check("in_ready", h(bus.in_ready), h((DP - m_cnt) >= NL));
        check("out_valid", h(bus.out_valid), h(m_cnt != 0));
        check("dropped", h(bus.dropped), h(m_drop));
        check("overflow", h(bus.overflow), h(m_ovf));
        if (m_cnt == 0) check("str_empty", bus.out_str, "");
        bus.in_valid  = mask;
        bus.in_pc     = {p1, p0};
        bus.in_inst   = {i1, i0};
        bus.out_ready = rdy;
        pop = (m_cnt != 0) && rdy;
        if (pop && q_pc.size() != 0) begin
            check("pc", h(bus.out_pc), h(q_pc.pop_front()));
            check("inst", h(bus.out_inst), h(q_inst.pop_front()));
            check("seq", h(bus.out_seq), h(q_seq.pop_front()));
            es = q_str.pop_front();
            if (es.len() != 0)
                check("str", bus.out_str.substr(0, es.len() - 1), es);
        end
        n  = int'(mask[0]) + int'(mask[1]);
        rd = (DP - m_cnt) >= NL;
        if (n > 0) begin
            if (rd) begin
                if (mask[0]) sb_push(p0, i0, m_seq, s0);
                if (mask[1]) sb_push(p1, i1, m_seq + 32'(mask[0]), s1);
                m_cnt += n;
            end else begin
                m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
                m_ovf  = 1'b1;
            end
            m_seq += 32'(n);
        end
        if (pop) m_cnt--;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit rdy);
        tick(2'b00, 0, 0, 0, 0, rdy, "", "");
    endtask

    task automatic do_reset();
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        clock  = 1'b0;
        reset  = 1'b1;
        bus.in_valid  = '0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Two lanes, drained back to empty.
        tick(2'b11, 32'h400000, 32'h00000000, 32'h400004, 32'h24020005,
             1, "nop", "addiu $2, $0,");
        repeat (3) idle(1);

        // Lane 1 only.
        tick(2'b10, 0, 0, 32'h400010, 32'h03e00008, 0, "", "jr $31");
        idle(0);
        idle(1);
        idle(1);

        // Fill to DEPTH with the consumer stalled, then overflow.
        for (int k = 0; k < 9; k++)
            tick(2'b11, 32'h401000 + 32'(16 * k), 32'h24000000 + 32'(k),
                 32'h401008 + 32'(16 * k), 32'h34000000 + 32'(k), 0, "", "");
        idle(1);

        // Near-full single-lane push with a pop the same cycle.
        for (int k = 0; k < 3; k++)
            tick(2'b01, 32'h402000 + 32'(4 * k), 32'h03e00008, 0, 0,
                 1, "jr $31", "");
        repeat (20) idle(1);

        // Bursts that wrap the tail past DEPTH-1.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++)
                tick(2'b11, 32'h410000 + 32'(64 * r + 8 * k), $urandom,
                     32'h410004 + 32'(64 * r + 8 * k), $urandom, 0, "", "");
            repeat (7) idle(1);
        end

        // Random masks and back-pressure.
        for (int k = 0; k < 300; k++)
            tick(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                 $urandom, ($urandom_range(0, 3) != 0), "", "");
        repeat (20) idle(1);

        // Reset with entries queued and overflow set.
        repeat (4)
            tick(2'b11, 32'h420000, 32'h0, 32'h420004, 32'h0, 0, "", "");
        tick(2'b01, 32'h420008, 32'h0, 0, 0, 0, "", "");
        idle(0);
        do_reset();
        tick(2'b01, 32'h500000, 32'h03e00008, 0, 0, 0, "jr $31", "");
        idle(1);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
